pmem_loader: RTL and testbench
==============================

# pmem_loader

Program-image loader for the picoMIPS program memory. It accepts a byte stream over a valid/ready handshake and packs the bytes MSB-first into instruction words. It writes each completed word into a writable program memory through a single-cycle write strobe. While loading, it holds the core off via `busy`, and it reports completion, word count and a byte checksum.

## Interface
Parameters:
- `DATA_WIDTH`, 8, datapath width field of an instruction word
- `ADDR_WIDTH`, 5, register-address field width (two fields per word)
- `PMEM_WIDTH`, 5, program-memory address width; depth = 2^PMEM_WIDTH
- `INST_WIDTH`, 6, opcode field width
- Derived `WORD_WIDTH` = INST_WIDTH + 2*ADDR_WIDTH + DATA_WIDTH (24 at defaults)
- Derived `BYTES_PER_WORD` = ceil(WORD_WIDTH/8) (3 at defaults)

Ports:
- `clk`  in  1  single clock, rising edge
- `nreset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to begin loading at address 0
- `rx_data`  in  8  incoming image byte
- `rx_valid`  in  1  `rx_data` is valid
- `rx_ready`  out  1  loader accepts a byte this cycle
- `we`  out  1  program-memory write strobe, one cycle per word
- `waddr`  out  PMEM_WIDTH  program-memory write address
- `wdata`  out  WORD_WIDTH  program-memory write word
- `busy`  out  1  load in progress; holds the core in reset
- `done`  out  1  sticky; set when a full image has been written
- `word_count`  out  PMEM_WIDTH+1  number of words written since `start`
- `checksum`  out  8  sum modulo 256 of all bytes accepted since `start`

## Operation
- States: IDLE, LOAD, WRITE, DONE (Moore outputs).
- **IDLE and DONE**
  - `rx_ready`=0, `busy`=0.
  - `start`=1 → LOAD; clears address, byte index, `word_count`, `checksum` and `done`.
- **LOAD**
  - `rx_ready`=1, `busy`=1.
  - A byte is accepted when `rx_valid`&`rx_ready`.
  - On accept: assembly register ← {assembly[WORD_WIDTH-9:0], rx_data}; `checksum` += rx_data; byte index increments.
  - The first byte of a word is most significant. Bits above WORD_WIDTH from the first byte are discarded.
  - On accepting byte BYTES_PER_WORD-1 (zero-based): byte index → 0, next state WRITE.
- **WRITE**
  - `rx_ready`=0, `busy`=1, `we`=1 for exactly this cycle.
  - `waddr` = current address; `wdata` = assembled word.
  - At the clock edge: `word_count` increments.
  - If address = 2^PMEM_WIDTH−1 → DONE and `done` is set. Otherwise the address increments (no wrap) → LOAD.
- `start` in LOAD or WRITE is ignored.
- `start` in DONE restarts a complete load.
- A byte presented during WRITE is not consumed; the source holds it until `rx_ready`.
- `rx_data` is ignored whenever `rx_ready`=0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE.
  - `rx_ready`, `we`, `busy`, `done` = 0.
  - `waddr`, `wdata`, `word_count`, `checksum` = 0.
- Reset mid-load abandons the partial word. Already-written memory words are left as they are.
- `start` sampled at edge N → `rx_ready`=1 and `busy`=1 from cycle N+1.
- Last byte of a word accepted at edge M → `we`=1 during cycle M+1, with `waddr`/`wdata` stable in that cycle.
- Throughput: minimum BYTES_PER_WORD+1 cycles per word. A full image at defaults takes a minimum of 128 cycles from the first accept to `done`.
- `done`, `word_count` and `checksum` are registered and update at the edge ending the accepting or writing cycle.

## Structure
- Package `pmem_pkg` holds:
  - the state enum `loader_state_t`
  - a function computing WORD_WIDTH from the four parameters
  - the BYTES_PER_WORD constant function
- The same package is shared with `pmem` so word widths stay consistent.
- One natural sub-module is `pmem_word_pack`: the byte shift/assembly register plus byte index, with `accept` in and `word_full` out.
- The FSM, address counter, word count and checksum stay in `pmem_loader`.

## Test plan
- **Reset:** assert `nreset`=0 mid-LOAD after 2 bytes → all outputs 0 immediately. After release with no `start`, `rx_ready` stays 0.
- **Single word:** `start`, then bytes 0xA5, 0x3C, 0x0F on consecutive cycles → exactly one `we` pulse, one cycle after the third accept, with `waddr`=0, `wdata`=0xA53C0F; `word_count`=1 and `checksum`=0xF0 afterward.
- **Full image:** bytes 0x00..0x5F back-to-back →
  - 32 `we` pulses
  - last pulse `waddr`=31, `wdata`=0x5D5E5F
  - then `done`=1, `busy`=0, `word_count`=32, `checksum`=0xD0.
- **Backpressure/gaps:** `rx_valid` toggled randomly, with a byte held through WRITE → no byte lost or duplicated, and `rx_ready`=0 in every WRITE cycle.
- **Start handling:** `start` pulsed during LOAD is ignored. `start` after DONE clears `done`, `word_count` and `checksum`, and the next write is at `waddr`=0.
- **Reset mid-load then restart:** reset after 5 bytes, then `start` → the first write is at `waddr`=0 with bytes from the new stream only.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared types and width helpers for the picoMIPS program memory and its loader.
// Keeping the word-width math here keeps the loader and pmem consistent.
package pmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  // An instruction word is opcode, two register-address fields and a data field.
  function automatic int calc_word_width(input int inst_width,
                                         input int addr_width,
                                         input int data_width);
    return inst_width + 2 * addr_width + data_width;
  endfunction

  function automatic int calc_bytes_per_word(input int word_width);
    return (word_width + 7) / 8;
  endfunction

endpackage

// File: rtl/pmem_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
// The master modport is the loader side; slave is the source/memory side.
interface pmem_loader_if
  import pmem_pkg::*;
#(
  parameter int PMEM_WIDTH = 5,
  parameter int WORD_WIDTH = calc_word_width(6, 5, 8)
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  we;
  logic [PMEM_WIDTH-1:0] waddr;
  logic [WORD_WIDTH-1:0] wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, we, waddr, wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata
  );

endinterface

// File: rtl/pmem_word_pack.sv
// Packs accepted bytes MSB-first into one instruction word and tracks the byte index.
// word_full marks the accept that completes the word.
module pmem_word_pack
  import pmem_pkg::*;
#(
  parameter int WORD_WIDTH     = 24,
  parameter int BYTES_PER_WORD = calc_bytes_per_word(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            rx_data,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  assign word_full = accept && (idx_q == LAST_IDX);
  assign word      = word_q;

  // Shifting left drops any bits of the first byte that sit above the word.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (accept) begin
      word_d = {word_q[WORD_WIDTH-9:0], rx_data};
      idx_d  = word_full ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/pmem_loader.sv
// Program-image loader: streams bytes into instruction words and writes them
// into program memory from address 0 upward, holding the core off while busy.
module pmem_loader
  import pmem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int PMEM_WIDTH = 5,
  parameter int INST_WIDTH = 6,
  localparam int WORD_WIDTH     = calc_word_width(INST_WIDTH, ADDR_WIDTH, DATA_WIDTH),
  localparam int BYTES_PER_WORD = calc_bytes_per_word(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  start,
  pmem_loader_if.master         bus,
  output logic                  busy,
  output logic                  done,
  output logic [PMEM_WIDTH:0]   word_count,
  output logic [7:0]            checksum
);

  localparam logic [PMEM_WIDTH-1:0] LAST_ADDR = '1;

  loader_state_t         state_q, state_d;
  logic [PMEM_WIDTH-1:0] addr_q, addr_d;
  logic [PMEM_WIDTH:0]   count_q, count_d;
  logic [7:0]            csum_q, csum_d;
  logic                  done_q, done_d;
  logic                  clear;
  logic                  accept;
  logic                  word_full;
  logic [WORD_WIDTH-1:0] word;

  // Moore handshake: ready is a pure function of the state, so accept is too.
  assign accept = bus.rx_valid && (state_q == ST_LOAD);

  pmem_word_pack #(
    .WORD_WIDTH    (WORD_WIDTH),
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_pack (
    .clk      (clk),
    .nreset   (nreset),
    .clear    (clear),
    .accept   (accept),
    .rx_data  (bus.rx_data),
    .word     (word),
    .word_full(word_full)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    csum_d       = csum_q;
    done_d       = done_q;
    clear        = 1'b0;
    bus.rx_ready = 1'b0;
    bus.we       = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          count_d = '0;
          csum_d  = '0;
          done_d  = 1'b0;
          clear   = 1'b1;
        end
      end
      ST_LOAD: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (accept) begin
          csum_d = csum_q + bus.rx_data;
        end
        if (word_full) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        bus.we  = 1'b1;
        busy    = 1'b1;
        count_d = count_q + 1'b1;
        // The image is exactly one full memory; the address never wraps.
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
    end
  end

  assign bus.waddr  = addr_q;
  assign bus.wdata  = word;
  assign word_count = count_q;
  assign checksum   = csum_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: reset, single word, full image, backpressure,
// start handling and restart after a mid-load reset.
module tb_pmem_loader;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [5:0] word_count;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [4:0]  wr_addr[$];
  logic [23:0] wr_data[$];
  logic [7:0]  stream[$];

  pmem_loader_if #(.PMEM_WIDTH(5), .WORD_WIDTH(24)) bus ();

  pmem_loader dut (
    .clk       (clk),
    .nreset    (nreset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .word_count(word_count),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Record every write strobe; the loader must never be ready in a write cycle.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wr_addr.push_back(bus.waddr);
      wr_data.push_back(bus.wdata);
      checkOutput("ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
    end
  end

  task automatic applyReset();
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until it is accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int  n;
    logic ok;
    repeat (gap) begin
      bus.rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("done_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic clearLog();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    logic [7:0]  sum;
    logic [23:0] exp_word;
    int          nw;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset, then asynchronous reset in the middle of a word
    applyReset();
    checkOutput("reset_ready", {31'd0, bus.rx_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    pulseStart();
    checkOutput("start_ready", {31'd0, bus.rx_ready}, 32'd1);
    checkOutput("start_busy", {31'd0, busy}, 32'd1);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    #2 nreset = 1'b0;
    #1;
    checkOutput("rst_flags", {28'd0, bus.we, bus.rx_ready, busy, done}, 32'd0);
    checkOutput("rst_waddr", {27'd0, bus.waddr}, 32'd0);
    checkOutput("rst_wdata", {8'd0, bus.wdata}, 32'd0);
    checkOutput("rst_count", {26'd0, word_count}, 32'd0);
    checkOutput("rst_csum", {24'd0, checksum}, 32'd0);
    @(negedge clk) nreset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_ready", {31'd0, bus.rx_ready}, 32'd0);
    checkOutput("idle_writes", wr_addr.size(), 32'd0);

    // Single word
    clearLog();
    pulseStart();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h3C, 0);
    applyStimulus(8'h0F, 0);
    checkOutput("sw_we", {31'd0, bus.we}, 32'd1);
    checkOutput("sw_waddr", {27'd0, bus.waddr}, 32'd0);
    checkOutput("sw_wdata", {8'd0, bus.wdata}, 32'h00A53C0F);
    @(posedge clk);
    #1;
    checkOutput("sw_we_off", {31'd0, bus.we}, 32'd0);
    checkOutput("sw_count", {26'd0, word_count}, 32'd1);
    checkOutput("sw_csum", {24'd0, checksum}, 32'h000000F0);
    checkOutput("sw_pulses", wr_addr.size(), 32'd1);

    // Full image 0x00..0x5F back-to-back
    applyReset();
    clearLog();
    pulseStart();
    for (int i = 0; i < 96; i++) applyStimulus(8'(i), 0);
    waitDone();
    checkOutput("img_pulses", wr_addr.size(), 32'd32);
    nw = (wr_addr.size() < 32) ? wr_addr.size() : 32;
    for (int k = 0; k < nw; k++) begin
      exp_word = {8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)};
      checkOutput($sformatf("img_addr%0d", k), {27'd0, wr_addr[k]}, 32'(k));
      checkOutput($sformatf("img_data%0d", k), {8'd0, wr_data[k]}, {8'd0, exp_word});
    end
    if (nw == 32) checkOutput("img_last_data", {8'd0, wr_data[31]}, 32'h005D5E5F);
    checkOutput("img_busy", {31'd0, busy}, 32'd0);
    checkOutput("img_count", {26'd0, word_count}, 32'd32);
    checkOutput("img_csum", {24'd0, checksum}, 32'h000000D0);

    // Start after DONE restarts; start during LOAD is ignored
    clearLog();
    pulseStart();
    checkOutput("rs_done", {31'd0, done}, 32'd0);
    checkOutput("rs_count", {26'd0, word_count}, 32'd0);
    checkOutput("rs_csum", {24'd0, checksum}, 32'd0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    pulseStart();
    applyStimulus(8'h03, 0);
    checkOutput("rs_we", {31'd0, bus.we}, 32'd1);
    checkOutput("rs_waddr", {27'd0, bus.waddr}, 32'd0);
    checkOutput("rs_wdata", {8'd0, bus.wdata}, 32'h00010203);
    applyStimulus(8'h04, 0);
    applyStimulus(8'h05, 0);
    applyStimulus(8'h06, 0);
    checkOutput("rs_waddr2", {27'd0, bus.waddr}, 32'd1);
    checkOutput("rs_wdata2", {8'd0, bus.wdata}, 32'h00040506);
    @(posedge clk);
    #1;
    checkOutput("rs_count2", {26'd0, word_count}, 32'd2);
    checkOutput("rs_csum2", {24'd0, checksum}, 32'h00000015);

    // Backpressure: random gaps on rx_valid
    applyReset();
    clearLog();
    stream.delete();
    sum = 8'h00;
    for (int i = 0; i < 12; i++) begin
      stream.push_back(8'(8'h80 + i * 13));
      sum = sum + stream[i];
    end
    pulseStart();
    for (int i = 0; i < 12; i++) applyStimulus(stream[i], $urandom_range(0, 3));
    @(posedge clk);
    #1;
    checkOutput("bp_pulses", wr_addr.size(), 32'd4);
    nw = (wr_addr.size() < 4) ? wr_addr.size() : 4;
    for (int k = 0; k < nw; k++) begin
      exp_word = {stream[3 * k], stream[3 * k + 1], stream[3 * k + 2]};
      checkOutput($sformatf("bp_addr%0d", k), {27'd0, wr_addr[k]}, 32'(k));
      checkOutput($sformatf("bp_data%0d", k), {8'd0, wr_data[k]}, {8'd0, exp_word});
    end
    checkOutput("bp_count", {26'd0, word_count}, 32'd4);
    checkOutput("bp_csum", {24'd0, checksum}, {24'd0, sum});

    // Reset after 5 bytes, then a fresh load
    applyReset();
    pulseStart();
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h91 + i), 0);
    applyReset();
    clearLog();
    pulseStart();
    applyStimulus(8'hC1, 0);
    applyStimulus(8'hC2, 0);
    applyStimulus(8'hC3, 0);
    @(posedge clk);
    #1;
    checkOutput("rr_pulses", wr_addr.size(), 32'd1);
    if (wr_addr.size() > 0) begin
      checkOutput("rr_waddr", {27'd0, wr_addr[0]}, 32'd0);
      checkOutput("rr_wdata", {8'd0, wr_data[0]}, 32'h00C1C2C3);
    end
    checkOutput("rr_count", {26'd0, word_count}, 32'd1);
    checkOutput("rr_csum", {24'd0, checksum}, 32'h00000046);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
